// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide scheduler owning HI/LO for the 5-stage MIPS pipeline.
// Operands are latched at start; results are committed to HI/LO on the last busy edge.
module muldiv_sched #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    localparam int unsigned MaxLat = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     rs_q, rs_d, rt_q, rt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_abs, b_abs, div_b, q_mag, r_mag, quo, rem;
    logic [31:0] res_hi, res_lo;
    logic        signed_div, div_zero;

    // Divide on magnitudes and fix signs afterwards; this also yields
    // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        prod_s     = {{32{rs_q[31]}}, rs_q} * {{32{rt_q[31]}}, rt_q};
        prod_u     = {32'd0, rs_q} * {32'd0, rt_q};
        signed_div = (op_q == 2'd2);
        a_abs      = (signed_div && rs_q[31]) ? -rs_q : rs_q;
        b_abs      = (signed_div && rt_q[31]) ? -rt_q : rt_q;
        div_zero   = (rt_q == 32'd0);
        div_b      = div_zero ? 32'd1 : b_abs;
        q_mag      = a_abs / div_b;
        r_mag      = a_abs % div_b;
        quo        = (signed_div && (rs_q[31] ^ rt_q[31])) ? -q_mag : q_mag;
        rem        = (signed_div && rs_q[31]) ? -r_mag : r_mag;
        res_hi     = rem;
        res_lo     = quo;
        unique case (op_q)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (e_start) begin
                    case (e_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            op_d    = e_op[1:0];
                            rs_d    = e_rs;
                            rt_d    = e_rt;
                            cnt_d   = e_op[1] ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
                            state_d = StBusy;
                        end
                        3'd4:    hi_d = e_rs;
                        3'd5:    lo_d = e_rs;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    // Divide by zero leaves HI/LO untouched.
                    if (!(op_q[1] && div_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == StBusy);
    assign md_stall = d_md_use & (busy | (e_start & ~e_op[2]));

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: expected HI/LO pairs are queued at issue
// and popped when busy falls; latency, stall and reset behaviour are checked inline.
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_sched #(
        .MULT_LAT(5),
        .DIV_LAT (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .e_start (e_start),
        .e_op    (e_op),
        .e_rs    (e_rs),
        .e_rt    (e_rt),
        .d_md_use(d_md_use),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expectation and compare it against the current HI/LO.
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
        end
    endtask

    // Issue a mult/div op, count busy and stall cycles, then check the result.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic use_d, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_lat, input int exp_stall);
        int          nbusy;
        int          nstall;
        logic        glitch;
        logic [31:0] hi0;
        logic [31:0] lo0;
        sb.push_back('{hi: exp_hi, lo: exp_lo});
        hi0      = hi;
        lo0      = lo;
        glitch   = 1'b0;
        e_start  = 1'b1;
        e_op     = op;
        e_rs     = rs;
        e_rt     = rt;
        d_md_use = use_d;
        #1;
        nstall = int'(md_stall);
        nbusy  = 0;
        step();
        e_start = 1'b0;
        #1;
        while (busy && nbusy < 50) begin
            nbusy++;
            nstall += int'(md_stall);
            if (hi !== hi0 || lo !== lo0) glitch = 1'b1;
            step();
        end
        d_md_use = 1'b0;
        chk({tag, "_latency"}, 32'(nbusy), 32'(exp_lat));
        chk({tag, "_stall_cycles"}, 32'(nstall), 32'(exp_stall));
        chk({tag, "_no_glitch"}, 32'(glitch), 32'd0);
        pop_check(tag);
    endtask

    // Single-cycle mthi (op 4) / mtlo (op 5) with a D-stage HI/LO user present.
    task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] val);
        exp_t e;
        e = '{hi: (op == 3'd4) ? val : hi, lo: (op == 3'd5) ? val : lo};
        sb.push_back(e);
        e_start  = 1'b1;
        e_op     = op;
        e_rs     = val;
        e_rt     = 32'h0;
        d_md_use = 1'b1;
        #1;
        chk({tag, "_stall"}, 32'(md_stall), 32'd0);
        step();
        e_start  = 1'b0;
        d_md_use = 1'b0;
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        pop_check(tag);
    endtask

    initial begin
        reset    = 1'b1;
        e_start  = 1'b0;
        e_op     = 3'd0;
        e_rs     = 32'h0;
        e_rt     = 32'h0;
        d_md_use = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);

        issue("mult_m1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0);
        issue("multu_m1x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0);
        issue("mult_min_sq", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0,
              32'h4000_0000, 32'h0, 5, 0);
        issue("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        issue("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 10, 0);
        issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 10, 0);
        issue("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, 10, 0);

        // mult followed by mflo held in D: start cycle plus five busy cycles stall
        issue("stall_mult", 3'd0, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 5, 6);
        d_md_use = 1'b1;
        #1;
        chk("mflo_idle_stall", 32'(md_stall), 32'd0);
        d_md_use = 1'b0;

        move_to("mthi", 3'd4, 32'h1234_5678);
        move_to("mtlo", 3'd5, 32'h9ABC_DEF0);

        // Reserved opcode must leave everything alone
        e_start = 1'b1;
        e_op    = 3'd7;
        e_rs    = 32'hDEAD_BEEF;
        step();
        e_start = 1'b0;
        chk("reserved_busy", 32'(busy), 32'd0);
        chk("reserved_hi", hi, 32'h1234_5678);
        chk("reserved_lo", lo, 32'h9ABC_DEF0);

        move_to("pre_dz_hi", 3'd4, 32'hA);
        move_to("pre_dz_lo", 3'd5, 32'hB);
        issue("div_zero", 3'd2, 32'd55, 32'd0, 1'b0, 32'hA, 32'hB, 10, 0);
        issue("divu_zero", 3'd3, 32'd55, 32'd0, 1'b0, 32'hA, 32'hB, 10, 0);

        // Reset on busy cycle 3 of a mult aborts it
        e_start = 1'b1;
        e_op    = 3'd0;
        e_rs    = 32'd9;
        e_rt    = 32'd9;
        step();
        e_start = 1'b0;
        chk("abort_busy1", 32'(busy), 32'd1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        issue("mult_after_rst", 3'd0, 32'd3, 32'hFFFF_FFFC, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFF4, 5, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
